// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, grant owner, and
// the burst-length width helper.
package dmem_arb_pkg;

    typedef enum logic [1:0] {IDLE, CPU, DMA} state_e;
    typedef enum logic {GNT_CPU, GNT_DMA} gnt_e;

    function automatic int len_w(input int max_burst);
        return $clog2(max_burst) + 1;
    endfunction

endpackage

// File: rtl/dma_burst_ctr.sv
// DMA burst bookkeeping: latches base/length/direction at grant, then walks
// the address (wrapping at 2^ADDR_W) and counts beats down to the last one.
module dma_burst_ctr
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = 5,
    parameter int MAX_BURST = 8,
    parameter int LEN_W     = len_w(MAX_BURST)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_step,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [LEN_W-1:0]  i_len,
    input  logic              i_we,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_we,
    output logic              o_last
);

    logic [LEN_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [LEN_W-1:0]  w_len;

    // A zero-length request still performs one beat; oversize ones are capped.
    always_comb begin
        w_len = i_len;
        if (i_len == '0)
            w_len = LEN_W'(1);
        else if (i_len > LEN_W'(MAX_BURST))
            w_len = LEN_W'(MAX_BURST);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_addr <= '0;
            r_we   <= 1'b0;
        end else if (i_load) begin
            r_cnt  <= w_len;
            r_addr <= i_base;
            r_we   <= i_we;
        end else if (i_step) begin
            r_cnt  <= r_cnt - LEN_W'(1);
            r_addr <= r_addr + ADDR_W'(1);
        end
    end

    assign o_addr = r_addr;
    assign o_we   = r_we;
    assign o_last = (r_cnt == LEN_W'(1));

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-ported data memory between CPU load/store accesses
// and DMA bursts, round-robin on ties, one requester at a time.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8,
    parameter int LEN_W     = len_w(MAX_BURST)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [LEN_W-1:0]  dma_len,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ready,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_done,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    state_e            r_state;
    gnt_e              r_last;
    logic              w_cpu_win;
    logic              w_dma_load;
    logic [ADDR_W-1:0] w_dma_adr;
    logic              w_dma_we;
    logic              w_dma_last;

    // On a tie the CPU wins only if the DMA port was served last.
    assign w_cpu_win  = cpu_req && (!dma_req || r_last == GNT_DMA);
    assign w_dma_load = (r_state == IDLE) && dma_req && !w_cpu_win;

    dma_burst_ctr #(
        .ADDR_W   (ADDR_W),
        .MAX_BURST(MAX_BURST),
        .LEN_W    (LEN_W)
    ) u_burst (
        .clk   (clk),
        .reset (reset),
        .i_load(w_dma_load),
        .i_step(r_state == DMA),
        .i_base(dma_addr),
        .i_len (dma_len),
        .i_we  (dma_we),
        .o_addr(w_dma_adr),
        .o_we  (w_dma_we),
        .o_last(w_dma_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_last  <= GNT_DMA;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_cpu_win)
                        r_state <= CPU;
                    else if (dma_req)
                        r_state <= DMA;
                end
                CPU: begin
                    r_state <= IDLE;
                    r_last  <= GNT_CPU;
                end
                DMA: begin
                    if (w_dma_last) begin
                        r_state <= IDLE;
                        r_last  <= GNT_DMA;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Write enable is also gated by reset so an in-flight write is killed
    // in the very cycle reset asserts.
    always_comb begin
        mem_wren  = 1'b0;
        mem_adr   = '0;
        mem_din   = '0;
        cpu_ready = 1'b0;
        cpu_rdata = '0;
        dma_ready = 1'b0;
        dma_rdata = '0;
        dma_done  = 1'b0;
        case (r_state)
            CPU: begin
                mem_wren  = cpu_we && reset;
                mem_adr   = cpu_addr;
                mem_din   = cpu_wdata;
                cpu_ready = 1'b1;
                cpu_rdata = mem_dout;
            end
            DMA: begin
                mem_wren  = w_dma_we && reset;
                mem_adr   = w_dma_adr;
                mem_din   = dma_wdata;
                dma_ready = 1'b1;
                dma_rdata = mem_dout;
                dma_done  = w_dma_last;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter with a behavioural memory
// model; a monitor thread checks every beat against queued expectations.
module tb_dmem_arbiter;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 4;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] adr;
        logic [DATA_W-1:0] data;
        logic              done;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              cpu_req = 1'b0, cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic              cpu_ready;
    logic [DATA_W-1:0] cpu_rdata;
    logic              dma_req = 1'b0, dma_we = 1'b0;
    logic [ADDR_W-1:0] dma_addr = '0;
    logic [LEN_W-1:0]  dma_len = '0;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_ready, dma_done;
    logic [DATA_W-1:0] dma_rdata;
    logic              mem_wren;
    logic [ADDR_W-1:0] mem_adr;
    logic [DATA_W-1:0] mem_din, mem_dout;

    logic [DATA_W-1:0] tb_mem [32];
    logic [DATA_W-1:0] model  [32];
    logic [ADDR_W-1:0] dma_base_t = '0;
    logic [DATA_W-1:0] dma_seed = '0;
    exp_t cpu_q[$];
    exp_t dma_q[$];
    int   order_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Memory behind the arbiter, plus a DMA source whose beat k (1-based)
    // carries seed+k.
    always @(posedge clk) if (mem_wren) tb_mem[mem_adr] <= mem_din;
    assign mem_dout  = tb_mem[mem_adr];
    assign dma_wdata = dma_seed + 32'(ADDR_W'(mem_adr - dma_base_t)) + 32'd1;

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_len(dma_len),
        .dma_wdata(dma_wdata), .dma_ready(dma_ready), .dma_rdata(dma_rdata), .dma_done(dma_done),
        .mem_wren(mem_wren), .mem_adr(mem_adr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    function automatic void chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endfunction

    task automatic monitor();
        bit in_burst = 0;
        exp_t e;
        logic [DATA_W-1:0] d;
        forever begin
            @(negedge clk);
            if (!reset) begin
                in_burst = 0;
            end else if (cpu_ready && dma_ready) begin
                chk(0, "both_ready", {62'b0, cpu_ready, dma_ready}, 64'd0);
            end else if (cpu_ready) begin
                order_q.push_back(0);
                if (cpu_q.size() == 0) chk(0, "cpu_unexpected", 64'(mem_adr), 64'd0);
                else begin
                    e = cpu_q.pop_front();
                    d = e.we ? mem_din : cpu_rdata;
                    chk({mem_wren, mem_adr, d, dma_done} == {e.we, e.adr, e.data, 1'b0} && dma_rdata == '0,
                        "cpu_beat", 64'({mem_wren, mem_adr, d, dma_done}), 64'({e.we, e.adr, e.data, 1'b0}));
                end
            end else if (dma_ready) begin
                if (!in_burst) order_q.push_back(1);
                in_burst = !dma_done;
                if (dma_q.size() == 0) chk(0, "dma_unexpected", 64'(mem_adr), 64'd0);
                else begin
                    e = dma_q.pop_front();
                    d = e.we ? mem_din : dma_rdata;
                    chk({mem_wren, mem_adr, d, dma_done} == {e.we, e.adr, e.data, e.done} && cpu_rdata == '0,
                        "dma_beat", 64'({mem_wren, mem_adr, d, dma_done}), 64'({e.we, e.adr, e.data, e.done}));
                end
            end else begin
                chk({mem_wren, mem_adr, mem_din, dma_done} == '0 && cpu_rdata == '0 && dma_rdata == '0,
                    "idle_zero", 64'({mem_wren, mem_adr, mem_din}), 64'd0);
            end
        end
    endtask

    task automatic cpu_op(input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
        exp_t e;
        int n = 0;
        bit got = 0;
        e.we = we; e.adr = a; e.done = 0;
        if (we) begin e.data = wd; model[a] = wd; end
        else e.data = model[a];
        cpu_q.push_back(e);
        cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_req = 1'b1;
        while (!got && n < 50) begin @(negedge clk); n++; got = cpu_ready; end
        chk(got && n == 2, "cpu_latency", 64'(n), 64'd2);
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_we = 1'($urandom); cpu_addr = ADDR_W'($urandom); cpu_wdata = $urandom;
        chk(cpu_q.size() == 0, "cpu_q_drain", 64'(cpu_q.size()), 64'd0);
    endtask

    function automatic int eff_len(input int len);
        return (len == 0) ? 1 : ((len > 8) ? 8 : len);
    endfunction

    function automatic void push_burst(input bit we, input logic [ADDR_W-1:0] base, input int beats,
                                       input logic [DATA_W-1:0] seed, input bit last_done);
        exp_t e;
        for (int i = 0; i < beats; i++) begin
            e.we = we; e.adr = base + ADDR_W'(i);
            e.done = last_done && (i == beats - 1);
            if (we) begin e.data = seed + 32'(i + 1); model[e.adr] = e.data; end
            else e.data = model[e.adr];
            dma_q.push_back(e);
        end
    endfunction

    task automatic dma_op(input bit we, input logic [ADDR_W-1:0] base, input int len, input logic [DATA_W-1:0] seed);
        int eff = eff_len(len);
        int n = 0, first = -1;
        bit done = 0;
        push_burst(we, base, eff, seed, 1'b1);
        dma_base_t = base; dma_seed = seed;
        dma_we = we; dma_addr = base; dma_len = LEN_W'(len); dma_req = 1'b1;
        while (!done && n < 200) begin
            @(negedge clk); n++;
            if (dma_ready && first < 0) first = n;
            if (dma_ready && dma_done) done = 1;
            if (first == n) begin
                // Controls are don't-care once granted; scramble them.
                @(posedge clk); #1;
                dma_req = 1'b0; dma_addr = ADDR_W'($urandom); dma_we = 1'($urandom); dma_len = LEN_W'($urandom);
            end
        end
        chk(done && first == 2 && n == eff + 1, "dma_timing", {32'(first), 32'(n)}, {32'd2, 32'(eff + 1)});
        @(posedge clk); #1;
        chk(dma_q.size() == 0, "dma_q_drain", 64'(dma_q.size()), 64'd0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int n, dn, cr, cnt;
        bit ok;
        exp_t e;
        for (int i = 0; i < 32; i++) model[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        chk({cpu_ready, dma_ready, dma_done, mem_wren, mem_adr, mem_din} == '0 && cpu_rdata == '0 && dma_rdata == '0,
            "reset_outputs", 64'({cpu_ready, dma_ready, dma_done, mem_wren, mem_adr}), 64'd0);
        #3 reset = 1'b1;
        @(posedge clk); #1;
        fork monitor(); join_none

        for (int a = 0; a < 32; a++) cpu_op(1'b1, ADDR_W'(a), $urandom);

        cpu_op(1'b1, 5'd3, 32'hDEADBEEF);
        cpu_op(1'b0, 5'd3, 32'h0);
        dma_op(1'b1, 5'd30, 4, 32'd0);
        cpu_op(1'b0, 5'd0, 32'h0);
        chk(cpu_q.size() == 0 && model[0] == 32'd3 && tb_mem[0] == 32'd3, "wrap_word0", 64'(tb_mem[0]), 64'd3);
        dma_op(1'b0, 5'd28, 0, 32'd0);
        dma_op(1'b1, 5'd12, 15, 32'h1000);
        dma_op(1'b0, 5'd12, 8, 32'd0);

        // Both ports held from reset: CPU, DMA, CPU, DMA, CPU, DMA.
        pulse_reset();
        order_q.delete();
        for (int k = 0; k < 3; k++) begin
            e.we = 1'b1; e.adr = 5'd20; e.data = 32'h5555_0000; e.done = 1'b0;
            cpu_q.push_back(e);
            model[20] = e.data;
            push_burst(1'b1, 5'd24, 2, 32'h700, 1'b1);
        end
        cpu_we = 1'b1; cpu_addr = 5'd20; cpu_wdata = 32'h5555_0000; cpu_req = 1'b1;
        dma_base_t = 5'd24; dma_seed = 32'h700;
        dma_we = 1'b1; dma_addr = 5'd24; dma_len = 4'd2; dma_req = 1'b1;
        n = 0; cnt = 0;
        while (cnt < 3 && n < 100) begin
            @(negedge clk); n++;
            if (dma_ready && dma_done) cnt++;
        end
        chk(n == 15, "contention_cycles", 64'(n), 64'd15);
        @(posedge clk); #1;
        cpu_req = 1'b0; dma_req = 1'b0;
        @(posedge clk); #1;
        ok = (order_q.size() == 6);
        for (int k = 0; k < 6 && ok; k++) if (order_q[k] != (k % 2)) ok = 0;
        chk(ok, "rr_order", 64'(order_q.size()), 64'd6);
        chk(cpu_q.size() == 0 && dma_q.size() == 0, "contention_drain", 64'(cpu_q.size() + dma_q.size()), 64'd0);

        // CPU request raised at beat 2 of a len-8 read burst.
        push_burst(1'b0, 5'd0, 8, 32'd0, 1'b1);
        e.we = 1'b0; e.adr = 5'd5; e.data = model[5]; e.done = 1'b0;
        cpu_q.push_back(e);
        dma_base_t = 5'd0; dma_we = 1'b0; dma_addr = 5'd0; dma_len = 4'd8; dma_req = 1'b1;
        n = 0;
        while (!dma_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        dma_req = 1'b0; cpu_we = 1'b0; cpu_addr = 5'd5; cpu_req = 1'b1;
        n = 0; dn = -1; cr = -1;
        while (cr < 0 && n < 50) begin
            @(negedge clk); n++;
            if (dma_ready && dma_done && dn < 0) dn = n;
            if (cpu_ready) cr = n;
        end
        chk(dn == 7 && cr == 9, "cpu_wait_burst", {32'(dn), 32'(cr)}, {32'd7, 32'd9});
        @(posedge clk); #1;
        cpu_req = 1'b0;
        chk(cpu_q.size() == 0 && dma_q.size() == 0, "midburst_drain", 64'(cpu_q.size() + dma_q.size()), 64'd0);

        // Reset during beat 3 of a len-6 write burst: only beats 1-2 land.
        push_burst(1'b1, 5'd10, 2, 32'h100, 1'b0);
        dma_base_t = 5'd10; dma_seed = 32'h100;
        dma_we = 1'b1; dma_addr = 5'd10; dma_len = 4'd6; dma_req = 1'b1;
        n = 0;
        while (!dma_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1 dma_req = 1'b0;
        @(negedge clk);
        @(posedge clk); #2 reset = 1'b0;
        #1;
        chk({mem_wren, dma_ready, dma_done, mem_adr} == '0 && dma_rdata == '0 && mem_din == '0,
            "reset_midburst_out", 64'({mem_wren, dma_ready, dma_done, mem_adr}), 64'd0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk); #1;
        chk(dma_q.size() == 0, "reset_beats_seen", 64'(dma_q.size()), 64'd0);
        for (int a = 10; a < 16; a++) cpu_op(1'b0, ADDR_W'(a), 32'h0);

        // Random sequential traffic on both ports.
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 1) == 0)
                cpu_op(1'($urandom), ADDR_W'($urandom), $urandom);
            else
                dma_op(1'($urandom), ADDR_W'($urandom), $urandom_range(0, 15), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-ported 32-word data memory between the processor's load/store path and a DMA/loader port. The arbiter sequences every memory access through a small FSM and serves one requester at a time. It uses round-robin arbitration on ties. DMA bursts of up to MAX_BURST words run with auto-incrementing addresses. It sits between the processor/DMA engines and the memory's WrEn/Adr/DataIn/DataOut pins.

## Interface
- ADDR_W, 5, word-address width (memory depth 2^ADDR_W)
- DATA_W, 32, data width
- MAX_BURST, 8, maximum DMA beats per grant; LEN_W = clog2(MAX_BURST)+1
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request; held with cpu_we/addr/wdata until cpu_ready
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  word address
- cpu_wdata  in  DATA_W  write data
- cpu_ready  out  1  access performed this cycle
- cpu_rdata  out  DATA_W  read data, valid while cpu_ready=1
- dma_req  in  1  burst request
- dma_we  in  1  burst direction, sampled at grant
- dma_addr  in  ADDR_W  burst base address, sampled at grant
- dma_len  in  LEN_W  beat count, sampled at grant
- dma_wdata  in  DATA_W  write data for current beat, valid while dma_ready=1
- dma_ready  out  1  one beat performed this cycle
- dma_rdata  out  DATA_W  read data, valid while dma_ready=1
- dma_done  out  1  high with the last beat of a burst
- mem_wren  out  1  to memory WrEn
- mem_adr  out  ADDR_W  to memory Adr
- mem_din  out  DATA_W  to memory DataIn
- mem_dout  in  DATA_W  from memory DataOut (combinational read)

## Operation
- FSM states:
  - IDLE: no memory access.
  - CPU: one beat for the CPU port.
  - DMA: one beat per cycle until the beat counter expires.
- Arbitration in IDLE:
  - Only cpu_req high → CPU.
  - Only dma_req high → DMA.
  - Both high → the port not granted last (last_grant bit). After reset, last_grant=DMA, so the CPU wins the first tie.
- At the IDLE→DMA edge, latch:
  - beat counter ← dma_len, clamped to 1..MAX_BURST (0 → 1; >MAX_BURST → MAX_BURST).
  - address ← dma_addr.
  - direction ← dma_we.
- CPU state:
  - mem_adr=cpu_addr, mem_din=cpu_wdata, mem_wren=cpu_we.
  - cpu_ready=1, cpu_rdata=mem_dout.
  - Next state IDLE; last_grant←CPU.
- DMA state, each beat:
  - mem_adr=latched address, mem_din=dma_wdata, mem_wren=latched direction.
  - dma_ready=1, dma_rdata=mem_dout.
  - Address increments modulo 2^ADDR_W (31 wraps to 0); counter decrements.
  - On the beat with counter==1: dma_done=1, next state IDLE, last_grant←DMA.
- Bursts are non-preemptible. cpu_req during a burst waits and wins the next IDLE if still asserted.
- dma_req and dma_* control inputs are ignored after grant. Deasserting dma_req does not abort a burst.
- A requester still asserting in IDLE after completion is re-arbitrated normally. Round-robin alternates on continuous contention.
- In IDLE: mem_wren=0, mem_adr=0, mem_din=0, both ready outputs 0. cpu_rdata and dma_rdata are 0 when their ready signal is low.

## Timing
- Reset (async assert, sync-safe release): state=IDLE, last_grant=DMA, counter=0, address=0. All outputs 0.
- Reset asserted mid-burst: the burst is dropped immediately and no further writes occur. The write in the cycle of assertion is suppressed because mem_wren is forced to 0 asynchronously.
- CPU latency: cpu_req high in IDLE at edge N → cpu_ready high in cycle N+1 → IDLE in N+2. Peak throughput is one CPU access per 2 cycles.
- DMA: grant at edge N → beats in cycles N+1..N+L. The IDLE gap is one cycle before the next grant.
- Writes commit at the rising edge ending the beat cycle. Reads are combinational within the beat cycle. Read-after-write on consecutive beats returns the new data.

## Structure
- Package dmem_arb_pkg: state enum (IDLE, CPU, DMA), grant-owner enum (GNT_CPU, GNT_DMA), LEN_W helper function.
- Sub-module dma_burst_ctr: latches base, length and direction; produces the current address, last-beat flag and wrap increment.
- Top level holds the FSM, last_grant, and the memory-port muxes.

## Test plan
- CPU write then read: write 0xDEADBEEF to addr 3, then read addr 3 → cpu_ready one cycle after each request, cpu_rdata=0xDEADBEEF. mem_wren high only during the write beat.
- DMA write burst with wrap: base 30, len 4, data 1,2,3,4 → mem_adr 30,31,0,1 on consecutive cycles, dma_done with the 4th beat. A CPU read of addr 0 afterwards returns 3.
- Simultaneous req from reset: CPU granted first. With both held continuously, grants alternate CPU, DMA burst, CPU, …
- CPU request mid-burst: a DMA len-8 burst with cpu_req raised at beat 2 → no cpu_ready until the burst ends. cpu_ready follows after one IDLE cycle.
- Length clamp: dma_len=0 → exactly one beat with dma_done. dma_len=15 → exactly 8 beats.
- Reset mid-burst: assert reset during beat 3 of a len-6 write burst → outputs 0 immediately, memory locations for beats 3–6 unchanged, FSM in IDLE after release.
